// File: rtl/filter_pkg.sv
// Shared constants and types for the FILTER sequencer and core.
// Coefficients are sign-magnitude: bit 9 sign, bits 8:0 magnitude.
package filter_pkg;
  localparam int NCOEF   = 12;
  localparam int SIGW    = 16;
  localparam int COEFW   = 10;
  localparam int TIMEOUT = 1024;

  localparam int COEF_SIGN    = 9;
  localparam int COEF_MAG_MSB = 8;
  localparam int COEF_MAGW    = 9;

  localparam int IDXW = 4;
  typedef logic [IDXW-1:0]         idx_t;
  typedef logic [COEFW-1:0]        coef_t;
  typedef logic signed [SIGW-1:0]  sample_t;

  localparam idx_t LAST_IDX = idx_t'(NCOEF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  function automatic logic idx_ok(input idx_t a);
    return a <= LAST_IDX;
  endfunction
endpackage

// File: rtl/filter_ctrl_if.sv
// Sequencer <-> FILTER core link: serial coefficient load plus start/done.
interface filter_ctrl_if;
  import filter_pkg::*;
  coef_t   flt_coef;
  logic    flt_coef_load;
  sample_t flt_sig_in;
  logic    flt_start;
  logic    flt_done;
  sample_t flt_sig_out;

  modport master (
    output flt_coef, flt_coef_load, flt_sig_in, flt_start,
    input  flt_done, flt_sig_out
  );
  modport slave (
    input  flt_coef, flt_coef_load, flt_sig_in, flt_start,
    output flt_done, flt_sig_out
  );
endinterface

// File: rtl/filter_coef_bank.sv
// 12x10 shadow coefficient bank: synchronous write, combinational read.
module filter_coef_bank
  import filter_pkg::*;
(
  input  logic  clk,
  input  logic  rst_an,
  input  logic  wr,
  input  idx_t  waddr,
  input  coef_t wdata,
  input  idx_t  raddr,
  output coef_t rdata
);
  coef_t mem [NCOEF];

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      for (int i = 0; i < NCOEF; i++) mem[i] <= '0;
    end else if (wr && idx_ok(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = idx_ok(raddr) ? mem[raddr] : '0;
endmodule

// File: rtl/filter_ctrl.sv
// Sequencer in front of the 6-section FILTER core: coefficient reload and one pass per tick.
// Optional WAIT watchdog enabled with `define FILTER_CTRL_TIMEOUT_EN.
module filter_ctrl
  import filter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_an,
  input  logic          sample_tick,
  input  sample_t       src_sample,
  input  logic          cw_wr,
  input  idx_t          cw_addr,
  input  coef_t         cw_data,
  input  logic          commit,
  input  logic          ovr_clr,
  filter_ctrl_if.master flt,
  output sample_t       out_sample,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun,
  output logic          timeout
);
  state_t  state_q, state_d;
  idx_t    idx_q;
  logic    pend_q;
  coef_t   coef_q, bank_rdata, load_val;
  logic    coef_load_q, start_q, valid_q, ovr_q;
  sample_t sig_in_q, out_q;
  logic    pend_eff, accept, drop;

  filter_coef_bank u_bank (
    .clk   (clk),
    .rst_an(rst_an),
    .wr    (cw_wr),
    .waddr (cw_addr),
    .wdata (cw_data),
    .raddr (idx_q),
    .rdata (bank_rdata)
  );

  // Same-cycle write to the index being streamed goes out in this load.
  assign load_val = (cw_wr && cw_addr == idx_q) ? cw_data : bank_rdata;

  // A commit arriving in IDLE counts immediately, so a coincident tick loses.
  assign pend_eff = pend_q | commit;
  assign accept   = sample_tick && state_q == ST_IDLE && !pend_eff;
  assign drop     = sample_tick && !accept;

`ifdef FILTER_CTRL_TIMEOUT_EN
  localparam int TCNTW = $clog2(TIMEOUT);
  localparam logic [TCNTW-1:0] TCNT_LAST = TCNTW'(TIMEOUT - 1);
  logic [TCNTW-1:0] tcnt_q;
  logic             tmo_hit;
  logic             tmo_q;
`endif

  always_comb begin
    state_d = state_q;
`ifdef FILTER_CTRL_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  if (pend_eff) state_d = ST_LOAD;
                else if (sample_tick) state_d = ST_ISSUE;
      ST_LOAD:  if (idx_q == LAST_IDX) state_d = ST_IDLE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (flt.flt_done) state_d = ST_IDLE;
`ifdef FILTER_CTRL_TIMEOUT_EN
        else if (tcnt_q == TCNT_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      pend_q      <= 1'b1;
      idx_q       <= '0;
      coef_q      <= '0;
      coef_load_q <= 1'b0;
      sig_in_q    <= '0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      out_q       <= '0;
      ovr_q       <= 1'b0;
    end else begin
      pend_q      <= (state_q == ST_IDLE && pend_eff) ? 1'b0 : (pend_q | commit);
      idx_q       <= (state_q == ST_LOAD && idx_q != LAST_IDX) ? idx_q + 1'b1 : '0;
      coef_load_q <= (state_q == ST_LOAD);
      if (state_q == ST_LOAD) coef_q <= load_val;
      if (accept) sig_in_q <= src_sample;
      start_q     <= (state_q == ST_ISSUE);
      valid_q     <= (state_q == ST_WAIT) && flt.flt_done;
      if (state_q == ST_WAIT && flt.flt_done) out_q <= flt.flt_sig_out;
      ovr_q       <= drop ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
    end
  end

`ifdef FILTER_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= (state_q == ST_WAIT) ? tcnt_q + 1'b1 : '0;
      tmo_q  <= tmo_hit ? 1'b1 : (ovr_clr ? 1'b0 : tmo_q);
    end
  end
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign flt.flt_coef      = coef_q;
  assign flt.flt_coef_load = coef_load_q;
  assign flt.flt_sig_in    = sig_in_q;
  assign flt.flt_start     = start_q;
  assign out_sample        = out_q;
  assign out_valid         = valid_q;
  assign busy              = (state_q != ST_IDLE);
  assign overrun           = ovr_q;
endmodule

// File: tb/tb_filter_ctrl.sv
// Directed bench for filter_ctrl with a behavioural FILTER core (done 40 cycles after start).
module tb_filter_ctrl;
  import filter_pkg::*;

  logic    clk = 1'b0;
  logic    rst_an = 1'b0;
  logic    sample_tick = 1'b0;
  sample_t src_sample = '0;
  logic    cw_wr = 1'b0;
  idx_t    cw_addr = '0;
  coef_t   cw_data = '0;
  logic    commit = 1'b0;
  logic    ovr_clr = 1'b0;
  sample_t out_sample;
  logic    out_valid, busy, overrun, timeout;

  filter_ctrl_if flt();

  filter_ctrl u_dut (
    .clk        (clk),
    .rst_an     (rst_an),
    .sample_tick(sample_tick),
    .src_sample (src_sample),
    .cw_wr      (cw_wr),
    .cw_addr    (cw_addr),
    .cw_data    (cw_data),
    .commit     (commit),
    .ovr_clr    (ovr_clr),
    .flt        (flt),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural core: output = input + 0x11, done pulse 40 cycles after start seen.
  logic model_en = 1'b1;
  int   dcnt = 0;
  always @(posedge clk) begin
    flt.flt_done <= 1'b0;
    if (!rst_an) begin
      dcnt             <= 0;
      flt.flt_sig_out  <= '0;
    end else if (flt.flt_start && model_en) begin
      dcnt <= 40;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        flt.flt_done    <= 1'b1;
        flt.flt_sig_out <= flt.flt_sig_in + 16'sh0011;
      end
    end
  end

  int    n_chk = 0;
  int    n_fail = 0;
  coef_t cap [16];
  int    cap_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_load(input string tag);
    int k = 0;
    while (!flt.flt_coef_load && k < 40) begin
      step();
      k++;
    end
    chk(tag, {31'd0, flt.flt_coef_load}, 32'd1);
  endtask

  // Record one coefficient stream; optionally write idx11 and commit mid-stream.
  task automatic capture(input int wr_at);
    cap_n = 0;
    while (flt.flt_coef_load && cap_n < 16) begin
      cap[cap_n] = flt.flt_coef;
      if (cap_n == wr_at) begin
        cw_wr = 1'b1; cw_addr = 4'd11; cw_data = 10'h1FF; commit = 1'b1;
      end else begin
        cw_wr = 1'b0; commit = 1'b0;
      end
      cap_n++;
      step();
    end
    cw_wr = 1'b0;
    commit = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 100) begin
      step();
      k++;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int nv, ns, kd, kv;
    logic [9:0] orv;

    // 1: reset state, then the automatic zero load
    step(); step();
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_valid",     {31'd0, out_valid}, 32'd0);
    chk("rst_coef_load", {31'd0, flt.flt_coef_load}, 32'd0);
    chk("rst_start",     {31'd0, flt.flt_start}, 32'd0);
    chk("rst_overrun",   {31'd0, overrun}, 32'd0);
    chk("rst_timeout",   {31'd0, timeout}, 32'd0);
    chk("rst_out",       {16'd0, out_sample}, 32'd0);
    rst_an = 1'b1;
    step();
    chk("boot_busy", {31'd0, busy}, 32'd1);
    wait_load("boot_load");
    capture(-1);
    chk("boot_len", cap_n, 12);
    orv = '0;
    for (int i = 0; i < 12; i++) orv |= cap[i];
    chk("boot_zero", {22'd0, orv}, 32'd0);
    chk("boot_idle", {31'd0, busy}, 32'd0);

    // 2: write two coefficients, commit, check the stream order
    cw_wr = 1'b1; cw_addr = 4'd0; cw_data = 10'h080; step();
    cw_addr = 4'd1; cw_data = 10'h300; step();
    cw_addr = 4'd12; cw_data = 10'h3FF; step();
    cw_wr = 1'b0; commit = 1'b1; step();
    commit = 1'b0;
    wait_load("ld2_start");
    capture(-1);
    chk("ld2_len", cap_n, 12);
    chk("ld2_c0", {22'd0, cap[0]}, 32'h080);
    chk("ld2_c1", {22'd0, cap[1]}, 32'h300);
    for (int i = 2; i < 12; i++) chk($sformatf("ld2_c%0d", i), {22'd0, cap[i]}, 32'h000);

    // 3: one filter pass
    sample_tick = 1'b1; src_sample = 16'sh0100; step();
    sample_tick = 1'b0;
    chk("p3_sig_in",  {16'd0, flt.flt_sig_in}, 32'h0100);
    chk("p3_start_a", {31'd0, flt.flt_start}, 32'd0);
    step();
    chk("p3_start_b", {31'd0, flt.flt_start}, 32'd1);
    step();
    chk("p3_start_c", {31'd0, flt.flt_start}, 32'd0);
    nv = 0; ns = 0; kd = -1; kv = -1;
    for (int k = 0; k < 80; k++) begin
      step();
      if (flt.flt_done)  kd = k;
      if (flt.flt_start) ns++;
      if (out_valid) begin
        nv++; kv = k;
        chk("p3_out", {16'd0, out_sample}, 32'h0111);
      end
    end
    chk("p3_nvalid", nv, 1);
    chk("p3_nstart", ns, 0);
    chk("p3_lat",    kv, kd + 1);
    chk("p3_ovr",    {31'd0, overrun}, 32'd0);

    // 4: dropped ticks and overrun clear
    sample_tick = 1'b1; src_sample = 16'sh0200; step();
    sample_tick = 1'b0; step(); step(); step();
    sample_tick = 1'b1; src_sample = 16'sh0777; step();
    sample_tick = 1'b0;
    chk("p4_ovr_wait", {31'd0, overrun}, 32'd1);
    wait_valid("p4_valid");
    chk("p4_out", {16'd0, out_sample}, 32'h0211);
    ovr_clr = 1'b1; step();
    ovr_clr = 1'b0;
    chk("p4_clr", {31'd0, overrun}, 32'd0);
    sample_tick = 1'b1; src_sample = 16'sh0555; commit = 1'b1; ovr_clr = 1'b1; step();
    sample_tick = 1'b0; commit = 1'b0; ovr_clr = 1'b0;
    chk("p4_set_wins", {31'd0, overrun}, 32'd1);
    chk("p4_sig_held", {16'd0, flt.flt_sig_in}, 32'h0200);
    chk("p4_loading",  {31'd0, busy}, 32'd1);
    wait_load("p4_load");
    capture(-1);
    chk("p4_len", cap_n, 12);
    ovr_clr = 1'b1; step();
    ovr_clr = 1'b0;
    chk("p4_clr2", {31'd0, overrun}, 32'd0);

    // 5: commit plus idx11 write during LOAD
    commit = 1'b1; step();
    commit = 1'b0;
    wait_load("p5_load1");
    capture(2);
    chk("p5_len1", cap_n, 12);
    chk("p5_c0_1", {22'd0, cap[0]}, 32'h080);
    chk("p5_c11_1", {22'd0, cap[11]}, 32'h1FF);
    chk("p5_gap", {31'd0, flt.flt_coef_load}, 32'd0);
    wait_load("p5_load2");
    capture(-1);
    chk("p5_len2", cap_n, 12);
    chk("p5_c1_2", {22'd0, cap[1]}, 32'h300);
    chk("p5_c11_2", {22'd0, cap[11]}, 32'h1FF);
    step();
    chk("p5_idle", {31'd0, busy}, 32'd0);

`ifdef FILTER_CTRL_TIMEOUT_EN
    // 6: watchdog with a core that never finishes
    model_en = 1'b0;
    sample_tick = 1'b1; src_sample = 16'sh0300; step();
    sample_tick = 1'b0;
    nv = 0;
    for (int k = 0; k < 1024; k++) begin
      step();
      if (out_valid) nv++;
    end
    chk("p6_tmo_early", {31'd0, timeout}, 32'd0);
    chk("p6_busy_early", {31'd0, busy}, 32'd1);
    step();
    chk("p6_tmo", {31'd0, timeout}, 32'd1);
    chk("p6_idle", {31'd0, busy}, 32'd0);
    chk("p6_novalid", nv + int'(out_valid), 0);
    chk("p6_held", {16'd0, out_sample}, 32'h0211);
    model_en = 1'b1;
    sample_tick = 1'b1; src_sample = 16'sh0400; step();
    sample_tick = 1'b0;
    wait_valid("p6_valid");
    chk("p6_out", {16'd0, out_sample}, 32'h0411);
    ovr_clr = 1'b1; step();
    ovr_clr = 1'b0;
    chk("p6_clr", {31'd0, timeout}, 32'd0);
`else
    chk("p6_tied", {31'd0, timeout}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
